am2901_useq: RTL and testbench

- Microprogram sequencer with microinstruction pipeline register; sits directly upstream of the Am2901 controller.
- Generates the control-store address `uaddr` each cycle from the registered microword, the condition flags, the return stack and the loop counter.
- Latches the control-store word and drives opcode `i[8:0]` and register addresses `a`/`b` into the controller.
- Feedback: controller/ALU flags `z`, `ovr`, `c4`, `f3` return as branch conditions (Am2910-lite).

---
 rtl/am2901_useq_if.sv | 30 +++
 rtl/am2901_useq.sv | 174 +++++++++++++++++
 tb/tb_am2901_useq.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/am2901_useq_if.sv
// Sequencer <-> control store / Am2901 controller bundle.
// Master drives hold, control-store word, map address and ALU flags; slave is the sequencer.
interface am2901_useq_if #(
    parameter int UADDR_W = 8
) ();
    logic               hold;
    logic [31:0]        ustore_data;
    logic [UADDR_W-1:0] map_addr;
    logic               z;
    logic               ovr;
    logic               c4;
    logic               f3;
    logic [UADDR_W-1:0] uaddr;
    logic [8:0]         i;
    logic [3:0]         a;
    logic [3:0]         b;
    logic               stack_full;
    logic               stack_empty;
    logic               stack_err;

    modport master (
        output hold, ustore_data, map_addr, z, ovr, c4, f3,
        input  uaddr, i, a, b, stack_full, stack_empty, stack_err
    );

    modport slave (
        input  hold, ustore_data, map_addr, z, ovr, c4, f3,
        output uaddr, i, a, b, stack_full, stack_empty, stack_err
    );
endinterface

// File: rtl/am2901_useq.sv
// Am2910-lite microprogram sequencer with microword pipeline register feeding an Am2901 controller.
// Optional sticky stack fault flag: define AM2901_USEQ_STACK_ERR_EN.
module am2901_useq #(
    parameter int UADDR_W     = 8,
    parameter int STACK_DEPTH = 4,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    am2901_useq_if.slave       bus
);
    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = PTR_W + 1;
    // NOP: Y=F, no writes, ADD, source AQ, a=b=0, op=JZ
    localparam logic [31:0] NOP_WORD = {9'b001_000_000, 4'd0, 4'd0, 4'd0, 8'd0, 2'd0, 1'b0};

    typedef enum logic [3:0] {
        OP_JZ   = 4'd0,
        OP_CJS  = 4'd1,
        OP_JMAP = 4'd2,
        OP_CJP  = 4'd3,
        OP_PUSH = 4'd4,
        OP_CRTN = 4'd5,
        OP_LDCT = 4'd6,
        OP_RPCT = 4'd7,
        OP_LOOP = 4'd8
    } op_e;

    logic [31:0]        r_pr;
    logic [UADDR_W-1:0] r_upc;
    logic [SP_W-1:0]    r_sp;
    logic [CNT_W-1:0]   r_cnt;
    logic [UADDR_W-1:0] r_stack [STACK_DEPTH];

    op_e                w_op;
    logic [7:0]         w_branch_raw;
    logic [UADDR_W-1:0] w_branch;
    logic [3:0]         w_flags;
    logic               w_cond;
    logic               w_full;
    logic               w_empty;
    logic [PTR_W-1:0]   w_tos_idx;
    logic [PTR_W-1:0]   w_wr_idx;
    logic [UADDR_W-1:0] w_tos;
    logic [UADDR_W-1:0] w_uaddr;
    logic               w_push;
    logic               w_pop;
    logic               w_cnt_load;
    logic               w_cnt_dec;
    logic               w_sp_clr;
    logic [STACK_DEPTH-1:0] w_wr_en;

    assign w_op         = op_e'(r_pr[14:11]);
    assign w_branch_raw = r_pr[10:3];
    assign w_branch     = UADDR_W'(w_branch_raw);
    assign w_flags      = {bus.f3, bus.c4, bus.ovr, bus.z};
    assign w_cond       = w_flags[r_pr[2:1]] ^ r_pr[0];

    assign w_full    = (r_sp == SP_W'(STACK_DEPTH));
    assign w_empty   = (r_sp == '0);
    assign w_tos_idx = PTR_W'(r_sp - SP_W'(1));
    assign w_tos     = w_empty ? '0 : r_stack[w_tos_idx];
    // A push into a full stack overwrites the current top instead of growing
    assign w_wr_idx  = w_full ? w_tos_idx : r_sp[PTR_W-1:0];

    always_comb begin
        w_uaddr    = r_upc;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_cnt_load = 1'b0;
        w_cnt_dec  = 1'b0;
        w_sp_clr   = 1'b0;
        case (w_op)
            OP_JZ: begin
                w_uaddr  = '0;
                w_sp_clr = 1'b1;
            end
            OP_CJS: begin
                if (w_cond) begin
                    w_uaddr = w_branch;
                    w_push  = 1'b1;
                end
            end
            OP_JMAP: w_uaddr = bus.map_addr;
            OP_CJP: begin
                if (w_cond) w_uaddr = w_branch;
            end
            OP_PUSH: begin
                w_push     = 1'b1;
                w_cnt_load = w_cond;
            end
            OP_CRTN: begin
                if (w_cond) begin
                    w_uaddr = w_tos;
                    w_pop   = 1'b1;
                end
            end
            OP_LDCT: w_cnt_load = 1'b1;
            OP_RPCT: begin
                if (r_cnt != '0) begin
                    w_uaddr   = w_branch;
                    w_cnt_dec = 1'b1;
                end
            end
            OP_LOOP: begin
                if (w_cond) w_pop = 1'b1;
                else        w_uaddr = w_tos;
            end
            default: ;
        endcase
    end

    generate
        for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_wr_en
            assign w_wr_en[gi] = w_push && (w_wr_idx == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pr  <= NOP_WORD;
            r_upc <= '0;
            r_cnt <= '0;
        end else if (!bus.hold) begin
            r_pr  <= bus.ustore_data;
            r_upc <= w_uaddr + UADDR_W'(1);
            if (w_cnt_load)     r_cnt <= CNT_W'(w_branch_raw);
            else if (w_cnt_dec) r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp <= '0;
        end else if (!bus.hold) begin
            if (w_sp_clr)                r_sp <= '0;
            else if (w_push && !w_full)  r_sp <= r_sp + SP_W'(1);
            else if (w_pop && !w_empty)  r_sp <= r_sp - SP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STACK_DEPTH; k++) r_stack[k] <= '0;
        end else if (!bus.hold) begin
            for (int k = 0; k < STACK_DEPTH; k++) begin
                if (w_wr_en[k]) r_stack[k] <= r_upc;
            end
        end
    end

`ifdef AM2901_USEQ_STACK_ERR_EN
    logic r_stack_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stack_err <= 1'b0;
        end else if (!bus.hold) begin
            if ((w_push && w_full) || (w_pop && w_empty)) r_stack_err <= 1'b1;
        end
    end

    assign bus.stack_err = r_stack_err;
`else
    assign bus.stack_err = 1'b0;
`endif

    assign bus.uaddr       = w_uaddr;
    assign bus.i           = r_pr[31:23];
    assign bus.a           = r_pr[22:19];
    assign bus.b           = r_pr[18:15];
    assign bus.stack_full  = w_full;
    assign bus.stack_empty = w_empty;
endmodule

// File: tb/tb_am2901_useq.sv
// Directed bench for am2901_useq: single-word decode table plus multi-cycle sequences.
module tb_am2901_useq;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [31:0] rom [256];

    am2901_useq_if #(.UADDR_W(8)) bus ();

    am2901_useq #(.UADDR_W(8), .STACK_DEPTH(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.ustore_data = rom[bus.uaddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef AM2901_USEQ_STACK_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    typedef struct {
        logic [3:0] op;
        logic [7:0] br;
        logic [1:0] sel;
        logic       pol;
        logic [3:0] flags;   // {f3, c4, ovr, z}
        logic [7:0] map;
        logic [7:0] exp_uaddr;
    } vec_t;

    vec_t vt [17];

    function automatic logic [31:0] mw(input logic [8:0] fi, input logic [3:0] fa, input logic [3:0] fb,
                                       input logic [3:0] op, input logic [7:0] br,
                                       input logic [1:0] sel, input logic pol);
        return {fi, fa, fb, op, br, sel, pol};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [3:0] f);
        {bus.f3, bus.c4, bus.ovr, bus.z} = f;
    endtask

    task automatic fill_cont();
        for (int k = 0; k < 256; k++) begin
            logic [7:0] kk;
            kk = 8'(k);
            rom[k] = mw({1'b1, kk}, kk[3:0], ~kk[3:0], 4'd9, 8'h00, 2'd0, 1'b0);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.hold = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [7:0] seq [8];
    logic [8:0] held_i;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.hold = 1'b0;
        bus.map_addr = 8'h00;
        set_flags(4'b0000);
        fill_cont();

        vt[0]  = '{4'd0, 8'h33, 2'd0, 1'b0, 4'b0000, 8'h00, 8'h00};
        vt[1]  = '{4'd1, 8'h40, 2'd0, 1'b0, 4'b0001, 8'h00, 8'h40};
        vt[2]  = '{4'd1, 8'h40, 2'd0, 1'b0, 4'b0000, 8'h00, 8'h01};
        vt[3]  = '{4'd2, 8'h11, 2'd0, 1'b0, 4'b0000, 8'h9C, 8'h9C};
        vt[4]  = '{4'd3, 8'h55, 2'd1, 1'b0, 4'b0010, 8'h00, 8'h55};
        vt[5]  = '{4'd3, 8'h55, 2'd2, 1'b1, 4'b0100, 8'h00, 8'h01};
        vt[6]  = '{4'd3, 8'h77, 2'd3, 1'b1, 4'b0111, 8'h00, 8'h77};
        vt[7]  = '{4'd3, 8'h77, 2'd3, 1'b0, 4'b0111, 8'h00, 8'h01};
        vt[8]  = '{4'd4, 8'h22, 2'd0, 1'b0, 4'b0001, 8'h00, 8'h01};
        vt[9]  = '{4'd5, 8'h00, 2'd0, 1'b0, 4'b0001, 8'h00, 8'h00};
        vt[10] = '{4'd5, 8'h00, 2'd0, 1'b0, 4'b0000, 8'h00, 8'h01};
        vt[11] = '{4'd6, 8'h05, 2'd0, 1'b0, 4'b0000, 8'h00, 8'h01};
        vt[12] = '{4'd7, 8'h66, 2'd0, 1'b0, 4'b0000, 8'h00, 8'h01};
        vt[13] = '{4'd8, 8'h00, 2'd0, 1'b0, 4'b0001, 8'h00, 8'h01};
        vt[14] = '{4'd8, 8'h00, 2'd0, 1'b0, 4'b0000, 8'h00, 8'h00};
        vt[15] = '{4'd12, 8'hAA, 2'd0, 1'b0, 4'b1111, 8'h00, 8'h01};
        vt[16] = '{4'd3, 8'h88, 2'd2, 1'b0, 4'b0100, 8'h00, 8'h88};

        // Reset state, then straight-line CONT sequencing
        do_reset();
        chk("rst_uaddr", 32'(bus.uaddr), 32'h00);
        chk("rst_i", 32'(bus.i), 32'h040);
        chk("rst_empty", 32'(bus.stack_empty), 32'h1);
        chk("rst_full", 32'(bus.stack_full), 32'h0);
        chk("rst_err", 32'(bus.stack_err), 32'h0);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("cont_uaddr", 32'(bus.uaddr), 32'(k));
            chk("cont_i", 32'(bus.i), 32'h100 + 32'(k - 1));
            $display("cont cycle %0d uaddr=%0h i=%0h", k, bus.uaddr, bus.i);
        end

        // Single-microword decode table: word at address 0, uPC = 1 when it sits in PR
        for (int n = 0; n < 17; n++) begin
            logic [7:0] nn;
            nn = 8'(n);
            fill_cont();
            rom[0] = mw(9'h080 + 9'(n), nn[3:0], ~nn[3:0], vt[n].op, vt[n].br, vt[n].sel, vt[n].pol);
            set_flags(vt[n].flags);
            bus.map_addr = vt[n].map;
            do_reset();
            step();
            chk("vec_uaddr", 32'(bus.uaddr), 32'(vt[n].exp_uaddr));
            chk("vec_i", 32'(bus.i), 32'h080 + 32'(n));
            chk("vec_ab", 32'({bus.a, bus.b}), 32'({nn[3:0], ~nn[3:0]}));
            $display("vec %0d op=%0d uaddr=%0h exp=%0h", n, vt[n].op, bus.uaddr, vt[n].exp_uaddr);
        end

        // uPC wraps from 0xFF to 0x00
        fill_cont();
        rom[0] = mw(9'h040, 4'd0, 4'd0, 4'd2, 8'h00, 2'd0, 1'b0);
        bus.map_addr = 8'hFF;
        set_flags(4'b0000);
        do_reset();
        step();
        chk("jmap_ff", 32'(bus.uaddr), 32'hFF);
        step();
        chk("upc_wrap", 32'(bus.uaddr), 32'h00);
        $display("wrap uaddr=%0h", bus.uaddr);

        // CJP at 0x05 taken (z=1) and not taken (z=0)
        for (int p = 0; p < 2; p++) begin
            fill_cont();
            rom[5] = mw(9'h040, 4'd0, 4'd0, 4'd3, 8'h20, 2'd0, 1'b0);
            set_flags(p == 0 ? 4'b0001 : 4'b0000);
            do_reset();
            repeat (6) step();
            chk("cjp05", 32'(bus.uaddr), p == 0 ? 32'h20 : 32'h06);
            $display("cjp05 z=%0b uaddr=%0h", bus.z, bus.uaddr);
        end

        // CJS 0x10 -> 0x40, CRTN back to 0x11
        fill_cont();
        rom[8'h10] = mw(9'h040, 4'd0, 4'd0, 4'd1, 8'h40, 2'd0, 1'b0);
        rom[8'h40] = mw(9'h040, 4'd0, 4'd0, 4'd5, 8'h00, 2'd0, 1'b0);
        set_flags(4'b0001);
        do_reset();
        repeat (17) step();
        chk("cjs_uaddr", 32'(bus.uaddr), 32'h40);
        chk("cjs_empty", 32'(bus.stack_empty), 32'h1);
        step();
        chk("crtn_uaddr", 32'(bus.uaddr), 32'h11);
        chk("crtn_empty", 32'(bus.stack_empty), 32'h0);
        step();
        chk("after_rtn_uaddr", 32'(bus.uaddr), 32'h12);
        chk("after_rtn_empty", 32'(bus.stack_empty), 32'h1);
        $display("subroutine return uaddr=%0h", bus.uaddr);

        // LDCT 3 at 0x2F, RPCT to 0x30 at 0x31: three branches then fall through
        fill_cont();
        rom[8'h2F] = mw(9'h040, 4'd0, 4'd0, 4'd6, 8'h03, 2'd0, 1'b0);
        rom[8'h31] = mw(9'h0C3, 4'd1, 4'd2, 4'd7, 8'h30, 2'd0, 1'b0);
        set_flags(4'b0000);
        do_reset();
        repeat (8'h30) step();
        chk("ldct_uaddr", 32'(bus.uaddr), 32'h30);
        seq = '{8'h31, 8'h30, 8'h31, 8'h30, 8'h31, 8'h30, 8'h31, 8'h32};
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rpct_seq", 32'(bus.uaddr), 32'(seq[k]));
            $display("rpct step %0d uaddr=%0h", k, bus.uaddr);
        end

        // Hold for 3 cycles with RPCT in PR and cnt = 2
        rom[8'h2F] = mw(9'h040, 4'd0, 4'd0, 4'd6, 8'h02, 2'd0, 1'b0);
        do_reset();
        repeat (8'h32) step();
        chk("hold_pre_uaddr", 32'(bus.uaddr), 32'h30);
        held_i = bus.i;
        chk("hold_pre_i", 32'(held_i), 32'h0C3);
        bus.hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_uaddr", 32'(bus.uaddr), 32'h30);
            chk("hold_i", 32'(bus.i), 32'h0C3);
            $display("hold cycle %0d uaddr=%0h i=%0h", k, bus.uaddr, bus.i);
        end
        bus.hold = 1'b0;
        seq = '{8'h31, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
        for (int k = 0; k < 4; k++) begin
            step();
            chk("hold_rel_seq", 32'(bus.uaddr), 32'(seq[k]));
            $display("release step %0d uaddr=%0h", k, bus.uaddr);
        end

        // Five pushes into a 4-deep stack, then async reset mid-sequence
        fill_cont();
        for (int k = 0; k < 5; k++) rom[k] = mw(9'h040, 4'd0, 4'd0, 4'd4, 8'h00, 2'd0, 1'b0);
        rom[5] = mw(9'h040, 4'd0, 4'd0, 4'd5, 8'h00, 2'd0, 1'b1);
        set_flags(4'b0000);
        do_reset();
        repeat (5) step();
        chk("push4_full", 32'(bus.stack_full), 32'h1);
        chk("push4_err", 32'(bus.stack_err), 32'h0);
        step();
        chk("push5_full", 32'(bus.stack_full), 32'h1);
        chk("push5_err", 32'(bus.stack_err), 32'(EXP_ERR));
        chk("push5_tos", 32'(bus.uaddr), 32'h05);
        $display("overflow tos=%0h full=%0b err=%0b", bus.uaddr, bus.stack_full, bus.stack_err);
        rst = 1'b1;
        #1;
        chk("async_rst_uaddr", 32'(bus.uaddr), 32'h00);
        chk("async_rst_err", 32'(bus.stack_err), 32'h0);
        chk("async_rst_empty", 32'(bus.stack_empty), 32'h1);
        chk("async_rst_full", 32'(bus.stack_full), 32'h0);
        chk("async_rst_i", 32'(bus.i), 32'h040);
        $display("async reset uaddr=%0h err=%0b", bus.uaddr, bus.stack_err);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_uaddr", 32'(bus.uaddr), 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
